uart_rx_core: RTL and testbench

//   8N1 UART receiver for the board serial line (iUART_RXD at top level), 50 MHz domain.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 24 ++
 rtl/uart_rx_core.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

  // Clocks per oversample tick (truncating division).
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Wrapping divider counter; clr_i restarts the phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              cnt_q <= '0;
    else if (clr_i || tick_o) cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, 16x oversampled, centre-sampled, valid/ready output.
// Optional even parity (11-bit frame) enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       iCLK_50,
  input  logic       iRST_N,
  input  logic       iRXD,
  input  logic       iREADY,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFRAME_ERR,
  output logic       oPARITY_ERR,
  output logic       oOVERRUN,
  output logic       oBUSY
);

  localparam int DIV  = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);

  logic                  rx_meta_q, rxs_q, rxs_dly_q;
  logic                  tick, fall;
  uart_rx_state_t        state_q, state_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                  load, frame_err;
  logic [7:0]            data_q;
  logic                  valid_q, fe_q, ovr_q;

  // The divider free-runs; start-edge phase uncertainty is under one tick.
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (iCLK_50),
    .rst_ni (iRST_N),
    .clr_i  (1'b0),
    .tick_o (tick)
  );

  assign fall = rxs_dly_q & ~rxs_q;

  // Two-flop synchroniser plus delay tap for edge detection; idles high.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
    end else begin
      rx_meta_q <= iRXD;
      rxs_q     <= rx_meta_q;
      rxs_dly_q <= rxs_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d, par_err;
`endif

  // Receive FSM state and bit-timing registers.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state: count ticks within a bit, sample at centre, shift LSB first.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
    par_err   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (fall) begin
        state_d  = ST_START;
        os_cnt_d = '0;
      end
      ST_START: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
          os_cnt_d = '0;
          if (rxs_q) state_d = ST_IDLE;
          else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end else os_cnt_d = os_cnt_q + 1'b1;
      end
      ST_DATA: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          os_cnt_d = '0;
          shift_d  = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else bit_cnt_d = bit_cnt_q + 1'b1;
        end else os_cnt_d = os_cnt_q + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          os_cnt_d  = '0;
          par_err_d = rxs_q ^ (^shift_q);
          state_d   = ST_STOP;
        end else os_cnt_d = os_cnt_q + 1'b1;
      end
`endif
      ST_STOP: if (tick) begin
        if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          os_cnt_d = '0;
          if (!rxs_q) begin
            frame_err = 1'b1;
            state_d   = ST_WAIT_IDLE;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_err_q) par_err = 1'b1;
            else           load    = 1'b1;
`else
            load = 1'b1;
`endif
          end
        end else os_cnt_d = os_cnt_q + 1'b1;
      end
      ST_WAIT_IDLE: if (rxs_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register and error pulses; a full register drops the new byte.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fe_q  <= frame_err;
      ovr_q <= 1'b0;
      if (load) begin
        if (valid_q && !iREADY) ovr_q <= 1'b1;
        else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && iREADY) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pe_q;
  // Parity error pulse, registered to align with the other flags.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) pe_q <= 1'b0;
    else         pe_q <= par_err;
  end
  assign oPARITY_ERR = pe_q;
`else
  assign oPARITY_ERR = 1'b0;
`endif

  assign oDATA      = data_q;
  assign oVALID     = valid_q;
  assign oFRAME_ERR = fe_q;
  assign oOVERRUN   = ovr_q;
  assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frames plus random frames against a frame-level model.
module tb_uart_rx_core;

  localparam int BIT = 16 * 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rdy;
  logic [7:0] data;
  logic       valid, fe, pe, ovr, busy;

  always #10 clk = ~clk;

  uart_rx_core dut (
    .iCLK_50     (clk),
    .iRST_N      (rst_n),
    .iRXD        (rxd),
    .iREADY      (rdy),
    .oDATA       (data),
    .oVALID      (valid),
    .oFRAME_ERR  (fe),
    .oPARITY_ERR (pe),
    .oOVERRUN    (ovr),
    .oBUSY       (busy)
  );

  int checks = 0;
  int failures = 0;

  // Observed events.
  int        fe_cnt = 0, pe_cnt = 0, ovr_cnt = 0;
  logic [7:0] rx_q[$];

  // Frame-level model.
  int        exp_fe = 0, exp_pe = 0, exp_ovr = 0;
  logic [7:0] exp_q[$];
  bit        m_full = 0;
  logic [7:0] m_held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: count pulses and capture handshaken bytes.
  always @(negedge clk) begin
    if (fe)  fe_cnt++;
    if (pe)  pe_cnt++;
    if (ovr) ovr_cnt++;
    if (valid && rdy) rx_q.push_back(data);
  end

  task automatic set_ready(input bit r);
    @(posedge clk); #1;
    rdy = r;
    if (r && m_full) begin
      exp_q.push_back(m_held);
      m_full = 0;
    end
  endtask

  task automatic bit_out(input logic b);
    rxd = b;
    repeat (BIT) @(posedge clk);
  endtask

  // Send one frame and update the model with its expected outcome.
  task automatic frame(input logic [7:0] d, input bit par_ok, input bit stop, input int gap);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par_ok ? ^d : ~^d);
`endif
    bit_out(stop);
    rxd = 1'b1;
    if (!stop) exp_fe++;
`ifdef UART_RX_PARITY_EN
    else if (!par_ok) exp_pe++;
`endif
    else if (rdy) exp_q.push_back(d);
    else if (m_full) exp_ovr++;
    else begin
      m_full = 1;
      m_held = d;
    end
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic cmp_all(input string tag);
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_pe"}, pe_cnt, exp_pe);
    check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    rdy   = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outs", {data, valid, fe, pe, ovr, busy}, 13'h0);
    rst_n = 1'b1;
    repeat (50) @(posedge clk); #1;

    // 1: byte held until consumed
    frame(8'h55, 1, 1, 20);
    check("t1_valid", valid, 1);
    check("t1_data", data, 8'h55);
    repeat (200) @(posedge clk); #1;
    check("t1_hold", {valid, data}, {1'b1, 8'h55});
    set_ready(1);
    @(posedge clk); #1;
    check("t1_drop", valid, 0);
    cmp_all("t1");

    // 2: short low glitch is a false start
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    rxd = 1'b1;
    repeat (400) @(posedge clk); #1;
    check("t2_busy", busy, 0);
    check("t2_valid", valid, 0);
    cmp_all("t2");

    // 3: framing error, then a clean frame
    frame(8'hA3, 1, 0, 20);
    check("t3_valid", valid, 0);
    frame(8'h3C, 1, 1, 20);
    cmp_all("t3");

    // 4: back-to-back with consumer stalled
    set_ready(0);
    frame(8'h12, 1, 1, 0);
    frame(8'h34, 1, 1, 20);
    check("t4_data", data, 8'h12);
    check("t4_valid", valid, 1);
    set_ready(1);
    repeat (2) @(posedge clk); #1;
    cmp_all("t4");

    // 5: reset mid-frame
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b0);
    rxd   = 1'b1;
    rst_n = 1'b0;
    m_full = 0;
    @(posedge clk); #1;
    check("t5_rst_outs", {data, valid, fe, pe, ovr, busy}, 13'h0);
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (BIT) @(posedge clk); #1;
    set_ready(0);
    frame(8'hC3, 1, 1, 20);
    check("t5_data", data, 8'hC3);
    set_ready(1);
    repeat (2) @(posedge clk); #1;
    cmp_all("t5");

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch then good parity
    frame(8'h01, 0, 1, 20);
    check("t6_valid", valid, 0);
    frame(8'h01, 1, 1, 20);
    cmp_all("t6");
`endif

    // Random frames: random byte, mostly-good stop/parity, random stall.
    for (int n = 0; n < 5; n++) begin
      set_ready(1'($urandom_range(0, 1)));
      frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 40));
    end
    set_ready(1);
    repeat (2) @(posedge clk); #1;
    cmp_all("rand");
    check("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
